// File: rtl/qspi_ram_arbiter.sv
// Two-requester arbiter driving a QPI serial RAM, one byte per transaction.
// Define QSPI_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (req_0 wins) otherwise.
module qspi_ram_arbiter #(
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        we_0,
  input  logic [25:0] addr_0,
  input  logic [7:0]  wdata_0,
  output logic        ack_0,
  input  logic        req_1,
  input  logic        we_1,
  input  logic [25:0] addr_1,
  input  logic [7:0]  wdata_1,
  output logic        ack_1,
  output logic [7:0]  rdata,
  output logic [1:0]  ram_bank,
  output logic        ram_csn,
  output logic        ram_clk,
  output logic [3:0]  ram_io_o,
  output logic [3:0]  ram_io_oe,
  input  logic [3:0]  ram_io_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_t;

  localparam bit         HAS_DUMMY  = (DUMMY_CYCLES > 0);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic [3:0]  rbuf_q, rbuf_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  bank_q, bank_d;
  logic        csn_q, csn_d;
  logic        clk_q, clk_d;
  logic [3:0]  io_o_q, io_o_d;
  logic [3:0]  io_oe_q, io_oe_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;

  logic        sel1;
  logic        sel_we;
  state_t      nst;
  logic [7:0]  ncnt;
  logic [7:0]  cmd_b;
  logic [23:0] addr_sh;

`ifdef QSPI_ARB_ROUND_ROBIN_EN
  // prio_q set means requester 1 wins a tie
  logic prio_q, prio_d;
  assign sel1 = req_1 && (!req_0 || prio_q);
`else
  assign sel1 = req_1 && !req_0;
`endif

  assign sel_we = sel1 ? we_1 : we_0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    bank_d  = bank_q;
    csn_d   = csn_q;
    clk_d   = clk_q;
    io_o_d  = io_o_q;
    io_oe_d = io_oe_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef QSPI_ARB_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    nst     = state_q;
    ncnt    = cnt_q + 8'd1;
    cmd_b   = we_q ? 8'h38 : 8'hEB;
    addr_sh = '0;

    case (state_q)
      S_IDLE: begin
        if (req_0 || req_1) begin
          owner_d = sel1;
          we_d    = sel_we;
          addr_d  = sel1 ? addr_1[23:0] : addr_0[23:0];
          wdata_d = sel1 ? wdata_1 : wdata_0;
          bank_d  = sel1 ? addr_1[25:24] : addr_0[25:24];
          state_d = S_CMD;
          cnt_d   = '0;
          phase_d = 1'b0;
          csn_d   = 1'b0;
          clk_d   = 1'b0;
          io_o_d  = sel_we ? 4'h3 : 4'hE;
          io_oe_d = '1;
`ifdef QSPI_ARB_ROUND_ROBIN_EN
          prio_d  = ~sel1;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          clk_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          clk_d   = 1'b0;
          if (state_q == S_DATA && !we_q) rbuf_d = ram_io_i;
          case (state_q)
            S_CMD:   if (cnt_q == 8'd1) begin nst = S_ADDR; ncnt = '0; end
            S_ADDR:  if (cnt_q == 8'd5) begin
                       nst  = (!we_q && HAS_DUMMY) ? S_DUMMY : S_DATA;
                       ncnt = '0;
                     end
            S_DUMMY: if (cnt_q == DUMMY_LAST) begin nst = S_DATA; ncnt = '0; end
            S_DATA:  if (cnt_q == 8'd1) begin nst = S_DONE; ncnt = '0; end
            default: ;
          endcase
          state_d = nst;
          cnt_d   = ncnt;
          addr_sh = addr_q << {ncnt, 2'b00};
          io_o_d  = '0;
          io_oe_d = '0;
          case (nst)
            S_CMD:  begin io_o_d = ncnt[0] ? cmd_b[3:0] : cmd_b[7:4]; io_oe_d = '1; end
            S_ADDR: begin io_o_d = addr_sh[23:20]; io_oe_d = '1; end
            S_DATA: if (we_q) begin
                      io_o_d  = ncnt[0] ? wdata_q[3:0] : wdata_q[7:4];
                      io_oe_d = '1;
                    end
            S_DONE: begin
                      csn_d  = 1'b1;
                      ack0_d = !owner_q;
                      ack1_d = owner_q;
                      if (!we_q) rdata_d = {rbuf_q, ram_io_i};
                    end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      bank_q  <= '0;
      csn_q   <= 1'b1;
      clk_q   <= 1'b0;
      io_o_q  <= '0;
      io_oe_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef QSPI_ARB_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      bank_q  <= bank_d;
      csn_q   <= csn_d;
      clk_q   <= clk_d;
      io_o_q  <= io_o_d;
      io_oe_q <= io_oe_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifdef QSPI_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  assign ack_0     = ack0_q;
  assign ack_1     = ack1_q;
  assign rdata     = rdata_q;
  assign ram_bank  = bank_q;
  assign ram_csn   = csn_q;
  assign ram_clk   = clk_q;
  assign ram_io_o  = io_o_q;
  assign ram_io_oe = io_oe_q;

endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// Directed bench for qspi_ram_arbiter (DUMMY_CYCLES=6) with a simple QPI RAM read-data model.
module tb_qspi_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
  logic [25:0] addr_0 = '0, addr_1 = '0;
  logic [7:0]  wdata_0 = '0, wdata_1 = '0;
  logic        ack_0, ack_1, ram_csn, ram_clk;
  logic [7:0]  rdata;
  logic [1:0]  ram_bank;
  logic [3:0]  ram_io_o, ram_io_oe, ram_io_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rd_byte = 8'h00;
  logic [3:0] nib_log [32];
  logic [3:0] oe_log  [32];
  logic [1:0] bank_log [32];
  int pcount = 0;

  qspi_ram_arbiter #(.DUMMY_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .ack_0(ack_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .ack_1(ack_1),
    .rdata(rdata), .ram_bank(ram_bank), .ram_csn(ram_csn), .ram_clk(ram_clk),
    .ram_io_o(ram_io_o), .ram_io_oe(ram_io_oe), .ram_io_i(ram_io_i)
  );

  always #5 clk = ~clk;

  // Log one entry per ram_clk high phase; read data is presented for ram_clk periods 14 and 15.
  always @(negedge clk) begin
    if (ram_csn) pcount = 0;
    else if (ram_clk) begin
      if (pcount < 32) begin
        nib_log[pcount]  = ram_io_o;
        oe_log[pcount]   = ram_io_oe;
        bank_log[pcount] = ram_bank;
      end
      pcount++;
    end
  end

  assign ram_io_i = (pcount == 15) ? rd_byte[7:4] : (pcount == 16) ? rd_byte[3:0] : 4'h0;

  task automatic do_txn(input bit who, input bit we, input logic [25:0] a,
                        input logic [7:0] wd, input int change_at, output int lat);
    lat = -1;
    if (who) begin req_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = wd; end
    else     begin req_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = wd; end
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == change_at) begin
        if (who) begin addr_1 = 26'h2_FFFFFF; req_1 = 1'b0; end
        else     begin addr_0 = 26'h2_FFFFFF; req_0 = 1'b0; end
      end
      if (ack_0 || ack_1) begin lat = n; break; end
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ram_csn !== 1'b1) begin n_bad++; $display("FAIL reset_csn got %b want 1", ram_csn); end
    n_cmp++; if (ram_clk !== 1'b0) begin n_bad++; $display("FAIL reset_clk got %b want 0", ram_clk); end
    n_cmp++; if (ram_io_o !== 4'h0 || ram_io_oe !== 4'h0) begin
      n_bad++; $display("FAIL reset_io got o=%h oe=%h want 0/0", ram_io_o, ram_io_oe); end
    n_cmp++; if (ram_bank !== 2'd0 || rdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_bank_rdata got %h/%h want 0/00", ram_bank, rdata); end
    n_cmp++; if (ack_0 !== 1'b0 || ack_1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_ack got %b%b want 00", ack_0, ack_1); end
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    logic [3:0] exp_n [8];
    int lat;
    exp_n = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    rd_byte = 8'hA5;
    @(posedge clk); #1;
    do_txn(1'b0, 1'b0, 26'h1_000010, 8'h00, 0, lat);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL read_latency got %0d want 33", lat); end
    n_cmp++; if (ack_0 !== 1'b1 || ack_1 !== 1'b0) begin
      n_bad++; $display("FAIL read_ack got %b%b want 10", ack_0, ack_1); end
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL read_rdata got %h want a5", rdata); end
    n_cmp++; if (ram_csn !== 1'b1 || ram_io_oe !== 4'h0) begin
      n_bad++; $display("FAIL read_done_bus got csn=%b oe=%h want 1/0", ram_csn, ram_io_oe); end
    n_cmp++; if (pcount != 16) begin n_bad++; $display("FAIL read_periods got %0d want 16", pcount); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (nib_log[i] !== exp_n[i] || oe_log[i] !== 4'hF) begin
        n_bad++; $display("FAIL read_nibble[%0d] got %h oe=%h want %h oe=f", i, nib_log[i], oe_log[i], exp_n[i]); end
    end
    for (int i = 8; i < 16; i++) begin
      n_cmp++; if (oe_log[i] !== 4'h0) begin
        n_bad++; $display("FAIL read_oe[%0d] got %h want 0", i, oe_log[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bank_log[i] !== 2'd1) begin
        n_bad++; $display("FAIL read_bank[%0d] got %0d want 1", i, bank_log[i]); end
    end
    @(posedge clk); #1;
    n_cmp++; if (ack_0 !== 1'b0) begin n_bad++; $display("FAIL read_ack_width got %b want 0", ack_0); end
  endtask

  task automatic test_write;
    logic [3:0] exp_n [10];
    int lat;
    exp_n = '{4'h3, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h3, 4'hC};
    @(posedge clk); #1;
    do_txn(1'b1, 1'b1, 26'h0_ABCDEF, 8'h3C, 0, lat);
    n_cmp++; if (lat != 21) begin n_bad++; $display("FAIL write_latency got %0d want 21", lat); end
    n_cmp++; if (ack_1 !== 1'b1 || ack_0 !== 1'b0) begin
      n_bad++; $display("FAIL write_ack got %b%b want 01", ack_0, ack_1); end
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL write_rdata_held got %h want a5", rdata); end
    n_cmp++; if (pcount != 10) begin n_bad++; $display("FAIL write_periods got %0d want 10", pcount); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (nib_log[i] !== exp_n[i] || oe_log[i] !== 4'hF || bank_log[i] !== 2'd0) begin
        n_bad++; $display("FAIL write_nibble[%0d] got %h oe=%h bank=%0d want %h oe=f bank=0",
                          i, nib_log[i], oe_log[i], bank_log[i], exp_n[i]); end
    end
  endtask

  task automatic test_contention;
    int who [4];
    int exp_who [4];
    int gap, last;
`ifdef QSPI_ARB_ROUND_ROBIN_EN
    exp_who = '{0, 1, 0, 1};
`else
    exp_who = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 26'h0_000001; wdata_0 = 8'h11;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 26'h2_000002; wdata_1 = 8'h22;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      gap = -1;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (ack_0 || ack_1) begin gap = n; break; end
      end
      who[k] = ack_1 ? 1 : 0;
      n_cmp++; if (gap != ((k == 0) ? 21 : 22)) begin
        n_bad++; $display("FAIL cont_gap[%0d] got %0d want %0d", k, gap, (k == 0) ? 21 : 22); end
      n_cmp++; if ((ack_0 && ack_1) || who[k] != exp_who[k]) begin
        n_bad++; $display("FAIL cont_grant[%0d] got ack=%b%b want requester %0d", k, ack_0, ack_1, exp_who[k]); end
      last = k;
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
    n_cmp++; if (last != 3) begin n_bad++; $display("FAIL cont_count got %0d want 3", last); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ram_csn !== 1'b1) begin n_bad++; $display("FAIL cont_idle_csn got %b want 1", ram_csn); end
  endtask

  task automatic test_input_change;
    logic [3:0] exp_n [8];
    int lat;
    exp_n = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    rd_byte = 8'h5A;
    @(posedge clk); #1;
    do_txn(1'b0, 1'b0, 26'h1_000010, 8'h00, 3, lat);
    n_cmp++; if (lat != 33 || ack_0 !== 1'b1) begin
      n_bad++; $display("FAIL chg_ack got lat=%0d ack_0=%b want 33/1", lat, ack_0); end
    n_cmp++; if (rdata !== 8'h5A) begin n_bad++; $display("FAIL chg_rdata got %h want 5a", rdata); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (nib_log[i] !== exp_n[i] || bank_log[i] !== 2'd1) begin
        n_bad++; $display("FAIL chg_nibble[%0d] got %h bank=%0d want %h bank=1", i, nib_log[i], bank_log[i], exp_n[i]); end
    end
    @(posedge clk); #1;
    n_cmp++; if (ram_csn !== 1'b1) begin n_bad++; $display("FAIL chg_no_regrant got csn=%b want 1", ram_csn); end
  endtask

  task automatic test_reset_mid_read;
    int lat;
    bit saw_ack;
    rd_byte = 8'hC3;
    saw_ack = 1'b0;
    @(posedge clk); #1;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 26'h1_000020;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack_0 || ack_1) saw_ack = 1'b1;
    end
    rst_n = 1'b0;
    req_0 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ram_csn !== 1'b1 || ram_io_oe !== 4'h0) begin
      n_bad++; $display("FAIL rst_mid_bus got csn=%b oe=%h want 1/0", ram_csn, ram_io_oe); end
    n_cmp++; if (rdata !== 8'h00 || ram_clk !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_regs got rdata=%h clk=%b want 00/0", rdata, ram_clk); end
    repeat (2) begin
      @(posedge clk); #1;
      if (ack_0 || ack_1) saw_ack = 1'b1;
    end
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, 26'h3_000100, 8'h00, 0, lat);
    n_cmp++; if (saw_ack) begin n_bad++; $display("FAIL rst_mid_no_ack got ack seen want none"); end
    n_cmp++; if (lat != 33 || ack_0 !== 1'b1) begin
      n_bad++; $display("FAIL rst_release_latency got %0d ack_0=%b want 33/1", lat, ack_0); end
    n_cmp++; if (rdata !== 8'hC3 || bank_log[0] !== 2'd3) begin
      n_bad++; $display("FAIL rst_release_data got rdata=%h bank=%0d want c3/3", rdata, bank_log[0]); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_input_change();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_ram_arbiter.md
QSPI_RAM_ARBITER -- requirements
Module: qspi_ram_arbiter

Interface
REQ-001 SHALL have parameter: DUMMY_CYCLES, default 6, number of ram_clk cycles between address and read data.
REQ-002 SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
REQ-003 SHALL have requester ports, x in {0,1}:
- req_x  in  1  request; held until ack_x
- we_x  in  1  1=write, 0=read
- addr_x  in  26  [25:24] bank, [23:0] byte address
- wdata_x  in  8  write byte
- ack_x  out  1  one-cycle completion pulse
REQ-004 SHALL have shared and RAM ports:
- rdata  out  8  read byte, valid with ack_x
- ram_bank  out  2  bank select
- ram_csn  out  1  chip select, active-low
- ram_clk  out  1  RAM clock
- ram_io_o  out  4  quad data out
- ram_io_oe  out  4  per-line output enable
- ram_io_i  in  4  quad data in

Function
REQ-005 SHALL serve one single-byte transaction at a time, in QPI mode only; RAM mode entry is outside this block.
REQ-006 SHALL use states IDLE -> CMD (2 nibbles) -> ADDR (6 nibbles) -> DUMMY (DUMMY_CYCLES, reads only) -> DATA (2 nibbles) -> DONE -> IDLE.
REQ-007 SHALL use command 0xEB for reads and 0x38 for writes; command, address addr[23:0] and data SHALL be sent MSB nibble first.
REQ-008 SHALL give each ram_clk period two clk cycles: low phase with new ram_io_o, then high phase.
- Read nibbles SHALL be captured from ram_io_i at the clk edge ending the high phase.
REQ-009 SHALL grant in IDLE in cycle T when any req_x is high.
- ram_csn SHALL be low T+1..T+2N, where N = 10 (write) or 10+DUMMY_CYCLES (read) ram_clk cycles.
- ack_x and rdata SHALL be valid at T+2N+1 (DONE), with ram_csn high.
- Next grant SHALL be no earlier than T+2N+2.
REQ-010 SHALL, for a read with DUMMY_CYCLES=6, give 33 cycles from grant to ack; for a write, 21 cycles.
REQ-011 SHALL load ram_bank from addr_x[25:24] at grant and hold it stable while ram_csn is low.
REQ-012 SHALL drive ram_io_oe=4'hF in CMD, ADDR and write DATA, and 4'h0 in IDLE, DUMMY, read DATA and DONE.
REQ-013 SHALL register the requester's we, addr and wdata at grant; later changes to requester inputs, including req_x deassertion, SHALL NOT affect the transaction in flight.
REQ-014 SHALL, on simultaneous requests, arbitrate as set by REQ-020; ack_x SHALL pulse only to the granted requester.
REQ-015 SHALL hold rdata until the next read completes; writes SHALL NOT change rdata.

Reset
REQ-016 SHALL, with rst_n low at a clk edge, set from the next cycle: state IDLE, ram_csn=1, ram_clk=0, ram_io_o=0, ram_io_oe=0, ram_bank=0, ack_0=ack_1=0, rdata=0, round-robin pointer=0.
REQ-017 SHALL abort a transaction in flight when reset occurs mid-operation, with no ack issued.
REQ-018 SHALL accept its first grant in the first cycle with rst_n high.

Configuration
REQ-019 SHALL use macro QSPI_ARB_ROUND_ROBIN_EN.
REQ-020 SHALL arbitrate as follows:
- Macro defined: round-robin; on simultaneous requests the requester not granted last wins; after reset requester 0 wins.
- Macro undefined: fixed priority, req_0 always wins; no pointer register is implemented.

Verification
REQ-021 Single read: req_0=1, we_0=0, addr_0=26'h1_000010, ram_io_i model returns 0xA5 -> ram_bank=1; ram_io_o nibbles E,B,0,0,0,0,1,0; ack_0 and rdata=0xA5 at grant+33.
REQ-022 Single write: req_1=1, we_1=1, addr_1=26'h0_ABCDEF, wdata_1=0x3C -> nibbles 3,8,A,B,C,D,E,F,3,C; ram_io_oe=F throughout; ack_1 at grant+21; rdata unchanged.
REQ-023 Contention: req_0 and req_1 held high for 4 transactions -> with macro, grants 0,1,0,1; without macro, grants 0,0,0,0.
REQ-024 Reset mid-read: rst_n low at grant+12 -> next cycle ram_csn=1, ram_io_oe=0, no ack; a new read after release completes normally.
REQ-025 Input change: addr_0 altered and req_0 dropped at grant+3 -> original address transmitted; ack_0 still pulses at grant+33.
